// File: rtl/operand_fetch_pkg.sv
// Shared types and default widths for the operand-fetch stage.
// Forwarding is compiled in only when OPERAND_FETCH_BYPASS_EN is defined.
package operand_fetch_pkg;

  localparam int DATA_WIDTH_DEF    = 64;
  localparam int LOG2_NUM_REGS_DEF = 5;
  localparam int NUM_REGS_DEF      = 32;
  localparam int TAG_WIDTH_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_RF      = 2'd0,
    SRC_FWD_ACC = 2'd1,
    SRC_FWD_RD  = 2'd2
  } src_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundles the upstream, register-file, writeback-snoop and execute-side signals.
// The slave modport is the operand_fetch view; master is the environment view.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LOG2_NUM_REGS = LOG2_NUM_REGS_DEF,
  parameter int TAG_WIDTH     = TAG_WIDTH_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [LOG2_NUM_REGS-1:0] in_rs0;
  logic [LOG2_NUM_REGS-1:0] in_rs1;
  logic                     in_use_rs0;
  logic                     in_use_rs1;
  logic [TAG_WIDTH-1:0]     in_tag;

  logic [1:0]               rf_read_en;
  logic [LOG2_NUM_REGS-1:0] rf_raddr_0;
  logic [LOG2_NUM_REGS-1:0] rf_raddr_1;
  logic [DATA_WIDTH-1:0]    rf_rdata_0;
  logic [DATA_WIDTH-1:0]    rf_rdata_1;

  logic                     wb_en;
  logic [LOG2_NUM_REGS-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_op0;
  logic [DATA_WIDTH-1:0]    out_op1;
  logic [TAG_WIDTH-1:0]     out_tag;

  modport slave (
    input  in_valid, in_rs0, in_rs1, in_use_rs0, in_use_rs1, in_tag,
    output in_ready,
    output rf_read_en, rf_raddr_0, rf_raddr_1,
    input  rf_rdata_0, rf_rdata_1,
    input  wb_en, wb_addr, wb_data,
    output out_valid, out_op0, out_op1, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs0, in_rs1, in_use_rs0, in_use_rs1, in_tag,
    input  in_ready,
    input  rf_read_en, rf_raddr_0, rf_raddr_1,
    output rf_rdata_0, rf_rdata_1,
    output wb_en, wb_addr, wb_data,
    input  out_valid, out_op0, out_op1, out_tag,
    output out_ready
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-operand source select: READ-cycle writeback, else accept-cycle writeback, else RF data.
// With OPERAND_FETCH_BYPASS_EN undefined the writeback inputs are ignored.
module operand_fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LOG2_NUM_REGS = LOG2_NUM_REGS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     accept_i,
  input  logic [LOG2_NUM_REGS-1:0] rs_i,
  input  logic                     use_i,
  input  logic                     read_phase_i,
  input  logic [LOG2_NUM_REGS-1:0] rs_q_i,
  input  logic                     use_q_i,
  input  logic                     wb_en_i,
  input  logic [LOG2_NUM_REGS-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  input  logic [DATA_WIDTH-1:0]    rf_rdata_i,
  output logic [DATA_WIDTH-1:0]    operand_o
);

  src_e                  src;
  logic [DATA_WIDTH-1:0] fwd_acc_data;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic                  acc_hit_q, acc_hit_d;
  logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic                  rd_hit;

  // The RF returns the pre-write value for a same-cycle write, so remember it here.
  always_comb begin
    acc_hit_d  = acc_hit_q;
    acc_data_d = acc_data_q;
    if (accept_i) begin
      acc_hit_d  = wb_en_i && (wb_addr_i == rs_i) && use_i;
      acc_data_d = wb_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hit_q  <= 1'b0;
      acc_data_q <= '0;
    end else begin
      acc_hit_q  <= acc_hit_d;
      acc_data_q <= acc_data_d;
    end
  end

  assign rd_hit       = read_phase_i && use_q_i && wb_en_i && (wb_addr_i == rs_q_i);
  assign fwd_acc_data = acc_data_q;

  always_comb begin
    src = SRC_RF;
    if (rd_hit)         src = SRC_FWD_RD;
    else if (acc_hit_q) src = SRC_FWD_ACC;
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{clk, reset, accept_i, rs_i, use_i, read_phase_i,
                          rs_q_i, wb_en_i, wb_addr_i};
  assign src          = SRC_RF;
  assign fwd_acc_data = '0;
`endif

  // NOTE: operand_o gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    operand_o = '0;
    if (use_q_i) begin
      unique case (src)
        SRC_FWD_RD:  operand_o = wb_data_i;
        SRC_FWD_ACC: operand_o = fwd_acc_data;
        default:     operand_o = rf_rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts an instruction, reads the RF, presents operands two cycles later.
// Build option OPERAND_FETCH_BYPASS_EN enables writeback forwarding in both operand muxes.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LOG2_NUM_REGS = LOG2_NUM_REGS_DEF,
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int TAG_WIDTH     = TAG_WIDTH_DEF
) (
  input logic           clk,
  input logic           reset,
  operand_fetch_if.slave bus
);

  state_e                   state_q, state_d;
  logic                     in_ready;
  logic                     accept;
  logic [LOG2_NUM_REGS-1:0] rs0_q, rs1_q;
  logic                     use0_q, use1_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [DATA_WIDTH-1:0]    out_op0_q, out_op1_q;
  logic [TAG_WIDTH-1:0]     out_tag_q;
  logic [DATA_WIDTH-1:0]    op0, op1;
  logic                     read_phase;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = READ;
      end
      READ:  state_d = VALID;
      VALID: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_d = bus.in_valid ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept     = bus.in_valid && in_ready;
  assign read_phase = (state_q == READ);

  assign bus.in_ready   = in_ready;
  assign bus.rf_read_en = accept ? {bus.in_use_rs1, bus.in_use_rs0} : 2'b00;
  assign bus.rf_raddr_0 = bus.in_rs0;
  assign bus.rf_raddr_1 = bus.in_rs1;
  assign bus.out_valid  = (state_q == VALID) && !reset;
  assign bus.out_op0    = out_op0_q;
  assign bus.out_op1    = out_op1_q;
  assign bus.out_tag    = out_tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rs0_q     <= '0;
      rs1_q     <= '0;
      use0_q    <= 1'b0;
      use1_q    <= 1'b0;
      tag_q     <= '0;
      out_op0_q <= '0;
      out_op1_q <= '0;
      out_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs0_q  <= bus.in_rs0;
        rs1_q  <= bus.in_rs1;
        use0_q <= bus.in_use_rs0;
        use1_q <= bus.in_use_rs1;
        tag_q  <= bus.in_tag;
      end
      // Outputs only move on the READ->VALID edge, so a stalled VALID holds them.
      if (read_phase) begin
        out_op0_q <= op0;
        out_op1_q <= op1;
        out_tag_q <= tag_q;
      end
    end
  end

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .LOG2_NUM_REGS(LOG2_NUM_REGS)) u_mux0 (
    .clk(clk), .reset(reset), .accept_i(accept),
    .rs_i(bus.in_rs0), .use_i(bus.in_use_rs0),
    .read_phase_i(read_phase), .rs_q_i(rs0_q), .use_q_i(use0_q),
    .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
    .rf_rdata_i(bus.rf_rdata_0), .operand_o(op0)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .LOG2_NUM_REGS(LOG2_NUM_REGS)) u_mux1 (
    .clk(clk), .reset(reset), .accept_i(accept),
    .rs_i(bus.in_rs1), .use_i(bus.in_use_rs1),
    .read_phase_i(read_phase), .rs_q_i(rs1_q), .use_q_i(use1_q),
    .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
    .rf_rdata_i(bus.rf_rdata_1), .operand_o(op1)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: RF model, transaction-level reference, directed + random stimulus.
// Define OPERAND_FETCH_BYPASS_EN to exercise the forwarding build.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int DW = 64;
  localparam int LW = 5;
  localparam int TW = 8;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_WIDTH(DW), .LOG2_NUM_REGS(LW), .TAG_WIDTH(TW)) bus ();

  operand_fetch #(.DATA_WIDTH(DW), .LOG2_NUM_REGS(LW), .NUM_REGS(32), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  // Register-file model: read data valid one cycle after read_en, same-cycle write returns old data.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      bus.rf_rdata_0 <= '0;
      bus.rf_rdata_1 <= '0;
    end else begin
      if (bus.rf_read_en[0]) bus.rf_rdata_0 <= rf_mem[bus.rf_raddr_0];
      if (bus.rf_read_en[1]) bus.rf_rdata_1 <= rf_mem[bus.rf_raddr_1];
      if (bus.wb_en) rf_mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  typedef struct {
    logic          use0, use1;
    logic [LW-1:0] rs0, rs1;
    logic [DW-1:0] op0, op1;
    logic [TW-1:0] tag;
  } txn_t;

  int            errors = 0;
  int            checks = 0;
  bit            m_inflight, m_out_valid;
  txn_t          m_fly;
  logic [DW-1:0] m_op0, m_op1;
  logic [TW-1:0] m_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Newest writeback wins when forwarding is built in.
  function automatic logic [DW-1:0] fwd(input logic [LW-1:0] rs, input logic [DW-1:0] base);
    if (BYP && bus.wb_en && (bus.wb_addr == rs)) return bus.wb_data;
    return base;
  endfunction

  task automatic cycle();
    bit         rdy, acc;
    logic [1:0] ren;
    #2;
    rdy = !reset && !m_inflight && (!m_out_valid || bus.out_ready);
    acc = rdy && bus.in_valid;
    ren = acc ? {bus.in_use_rs1, bus.in_use_rs0} : 2'b00;
    check("in_ready", bus.in_ready, rdy);
    check("rf_read_en", bus.rf_read_en, ren);
    if (ren[0]) check("rf_raddr_0", bus.rf_raddr_0, bus.in_rs0);
    if (ren[1]) check("rf_raddr_1", bus.rf_raddr_1, bus.in_rs1);
    check("out_valid", bus.out_valid, m_out_valid && !reset);
    check("out_op0", bus.out_op0, m_op0);
    check("out_op1", bus.out_op1, m_op1);
    check("out_tag", bus.out_tag, m_tag);
    if (reset) begin
      m_inflight  = 1'b0;
      m_out_valid = 1'b0;
      m_op0 = '0; m_op1 = '0; m_tag = '0;
    end else begin
      if (m_inflight) begin
        m_op0 = m_fly.use0 ? fwd(m_fly.rs0, m_fly.op0) : '0;
        m_op1 = m_fly.use1 ? fwd(m_fly.rs1, m_fly.op1) : '0;
        m_tag = m_fly.tag;
        m_out_valid = 1'b1;
        m_inflight  = 1'b0;
      end else if (m_out_valid && bus.out_ready) begin
        m_out_valid = 1'b0;
      end
      if (acc) begin
        m_fly.rs0  = bus.in_rs0;
        m_fly.rs1  = bus.in_rs1;
        m_fly.use0 = bus.in_use_rs0;
        m_fly.use1 = bus.in_use_rs1;
        m_fly.op0  = fwd(bus.in_rs0, rf_mem[bus.in_rs0]);
        m_fly.op1  = fwd(bus.in_rs1, rf_mem[bus.in_rs1]);
        m_fly.tag  = bus.in_tag;
        m_inflight = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [LW-1:0] rs0, input logic [LW-1:0] rs1,
                       input logic u0, input logic u1, input logic [TW-1:0] tag,
                       input logic ordy, input logic wbe, input logic [LW-1:0] wba,
                       input logic [DW-1:0] wbd);
    bus.in_valid   = iv;
    bus.in_rs0     = rs0;
    bus.in_rs1     = rs1;
    bus.in_use_rs0 = u0;
    bus.in_use_rs1 = u1;
    bus.in_tag     = tag;
    bus.out_ready  = ordy;
    bus.wb_en      = wbe;
    bus.wb_addr    = wba;
    bus.wb_data    = wbd;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    m_inflight = 1'b0; m_out_valid = 1'b0;
    m_op0 = '0; m_op1 = '0; m_tag = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs0 = '0; bus.in_rs1 = '0;
    bus.in_use_rs0 = 1'b0; bus.in_use_rs1 = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b1; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;

    // Preload R3 and R5 through the writeback port.
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd5, 64'h55);
    idle(1);

    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, '0, '0);
    idle(3);

    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 5'd5, 64'h1234);
    idle(3);

    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 5'd7, 64'h11);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd7, 64'h22);
    idle(3);

    // Stall the execute side while R2 is rewritten, with the next instruction waiting.
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, '0, '0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 5'd2, 64'h100 + i);
    drive(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, '0, '0);
    idle(3);

    drive(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, '0, '0);
    idle(3);

    // Reset lands in the READ cycle; the next issue must complete normally.
    drive(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0, '0, '0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd4, 64'h4444);
    drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, '0, '0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            {32'($urandom), 32'($urandom)});
    end
    reset = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
